bcd_bin_conv: RTL
=================

BCD_BIN_CONV -- requirements
Module: bcd_bin_conv

Interface
REQ-001 SHALL have parameter DIGITS, default 8, meaning the number of packed BCD digits in bcd_in; the only supported value is 8.
REQ-002 SHALL have port clk, input, 1 bit, the system clock; all state is updated on its rising edge.
REQ-003 SHALL have port rst_n, input, 1 bit, reset: asynchronous, active-low.
REQ-004 SHALL have port start, input, 1 bit, a conversion request that is sampled only in IDLE.
REQ-005 SHALL have port bcd_in, input, 32 bits, eight packed BCD digits with digit 0 in [3:0] and digit 7 in [31:28].
REQ-006 SHALL have port busy, output, 1 bit, high while a conversion is in progress.
REQ-007 SHALL have port done, output, 1 bit, a one-cycle pulse marking the update of bin_out and err.
REQ-008 SHALL have port bin_out, output, 32 bits, the unsigned binary result.
REQ-009 SHALL have port err, output, 1 bit, the invalid-digit flag, which is meaningful only with BCD_CHECK_EN.

Function
REQ-010 SHALL implement FSM states IDLE, CONV and DONE.
REQ-011 SHALL, in IDLE with start=1 at edge k, capture bcd_in into a 64-bit shift register {bcd[31:0], bin[31:0]=0}, clear the iteration counter, enter CONV, and drive busy=1 from edge k.
REQ-012 SHALL ignore bcd_in changes after edge k until the next accepted start.
REQ-013 SHALL, in CONV on each edge, shift the 64-bit register right by 1, then in each of the 8 BCD nibbles subtract 3 wherever the post-shift nibble is >= 8, and increment the counter.
REQ-014 SHALL perform exactly 32 CONV iterations, on edges k+1 through k+32, with the counter being 5 bits and not wrapping before exit.
REQ-015 SHALL enter DONE at edge k+32.
REQ-016 SHALL, at edge k+33, load bin_out with the bin field, pulse done=1 for exactly one cycle, drop busy to 0, and return to IDLE.
REQ-017 SHALL give a total latency of 33 cycles from the start-sampling edge to the edge that raises done.
REQ-018 SHALL hold bin_out and err stable between done pulses.
REQ-019 SHALL ignore start while busy=1 or in DONE, with no queuing.
REQ-020 SHALL accept start=1 on the first cycle after done, with no back-to-back gap beyond the DONE cycle.
REQ-021 SHALL produce a result equal to the decimal value of the 8 digits, at most 99,999,999 (0x05F5E0FF), zero-extended to 32 bits.
REQ-022 SHALL convert an all-zero input through the full 33-cycle path and produce bin_out=0.

Reset
REQ-023 SHALL, on rst_n=0 at any time, including mid-conversion, immediately force: state IDLE, busy=0, done=0, bin_out=0, err=0, shift register and counter = 0.
REQ-024 SHALL abandon any in-progress conversion on reset with no done pulse.
REQ-025 SHALL, after rst_n deasserts, accept start on the first rising edge at which rst_n=1.

Configuration
REQ-026 SHALL support macro BCD_CHECK_EN.
REQ-027 SHALL, when BCD_CHECK_EN is defined and any bcd_in nibble is > 9 at the accepting edge k, skip CONV, set bin_out=0 and err=1 with done pulsed at edge k+1 and busy high for that one cycle only, then return to IDLE.
REQ-028 SHALL, when BCD_CHECK_EN is defined and all nibbles are <= 9, set err=0 at the done edge.
REQ-029 SHALL, when BCD_CHECK_EN is undefined, tie err to 0, perform no digit check, and run the 33-cycle algorithm unmodified for every input, with the result for invalid digits being whatever the algorithm yields.

Verification
REQ-030 SHALL cover: bcd_in=0x12345678, start pulse -> after 33 cycles done=1, bin_out=0x00BC614E, err=0, busy=0.
REQ-031 SHALL cover: bcd_in=0x99999999 -> bin_out=0x05F5E0FF; bcd_in=0x00000000 -> bin_out=0x00000000, done at cycle 33.
REQ-032 SHALL cover: start held high continuously with bcd_in changed mid-conversion -> first result unaffected, second conversion accepted on the cycle after done, and done pulses exactly 34 cycles apart.
REQ-033 SHALL cover: rst_n pulsed low at iteration 15 of 0x00000042 -> all outputs 0 immediately and no done; a subsequent start produces bin_out=0x0000002A.
REQ-034 SHALL cover, with BCD_CHECK_EN: bcd_in=0x0000001A -> done at edge k+1, err=1, bin_out=0; next conversion of 0x00000010 -> err=0, bin_out=0x0000000A.
REQ-035 SHALL cover, without BCD_CHECK_EN: bcd_in=0x0000001A -> done at cycle 33 and err=0.

Source files
------------

// File: rtl/bcd_bin_conv.sv
// bcd_bin_conv: 8-digit packed BCD to unsigned binary, shift-right/subtract-3, 33-cycle latency.
// Define BCD_CHECK_EN to reject non-decimal digits (err=1, bin_out=0, done one cycle after start).
module bcd_bin_conv #(
    parameter int DIGITS = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [4*DIGITS-1:0]   bcd_in,
    output logic                  busy,
    output logic                  done,
    output logic [4*DIGITS-1:0]   bin_out,
    output logic                  err
);
    localparam int W = 4 * DIGITS;

    typedef enum logic [1:0] {IDLE, CONV, DONE} state_t;

    state_t         state;
    logic [2*W-1:0] sr;
    logic [2*W-1:0] shifted;
    logic [2*W-1:0] nxt;
    logic [4:0]     cnt;

    assign shifted = sr >> 1;
    assign nxt[W-1:0] = shifted[W-1:0];
    for (genvar d = 0; d < DIGITS; d++) begin : g_dig
        assign nxt[W+4*d +: 4] = (shifted[W+4*d +: 4] >= 4'd8) ? shifted[W+4*d +: 4] - 4'd3
                                                                : shifted[W+4*d +: 4];
    end

`ifdef BCD_CHECK_EN
    logic [DIGITS-1:0] bad_dig;
    logic              bad;
    logic              bad_q;
    for (genvar d = 0; d < DIGITS; d++) begin : g_chk
        assign bad_dig[d] = bcd_in[4*d +: 4] > 4'd9;
    end
    assign bad = |bad_dig;
`else
    assign err = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            sr      <= '0;
            cnt     <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            bin_out <= '0;
`ifdef BCD_CHECK_EN
            err     <= 1'b0;
            bad_q   <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: if (start) begin
                    busy <= 1'b1;
                    cnt  <= '0;
`ifdef BCD_CHECK_EN
                    bad_q <= bad;
                    sr    <= bad ? '0 : {bcd_in, {W{1'b0}}};
                    state <= bad ? DONE : CONV;
`else
                    sr    <= {bcd_in, {W{1'b0}}};
                    state <= CONV;
`endif
                end
                CONV: begin
                    sr  <= nxt;
                    cnt <= cnt + 5'd1;
                    if (cnt == 5'd31) state <= DONE;
                end
                default: begin
                    bin_out <= sr[W-1:0];
                    done    <= 1'b1;
                    busy    <= 1'b0;
                    state   <= IDLE;
`ifdef BCD_CHECK_EN
                    err     <= bad_q;
`endif
                end
            endcase
        end
    end
endmodule
